// File: rtl/e1ofn_tx_pkg.sv
// Shared types and helpers for the e1ofN network-interface transmitter.
// Holds the FSM state encoding, default sizing and the dual-rail encoder.
package e1ofn_tx_pkg;

    localparam int DEF_W     = 9;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        NEUTRAL = 2'd2
    } tx_state_t;

    // Returns {d1, d0}: the true rails carry the word, the false rails its complement.
    function automatic logic [2*DEF_W-1:0] dual_rail_enc(input logic [DEF_W-1:0] word);
        return {word, ~word};
    endfunction

endpackage

// File: rtl/e1ofn_tx_sync2.sv
// Two-flop synchronizer with asynchronous reset to 0.
// Shared by the e1ofN transmitter and receiver for the channel enable.
module sync2 (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/e1ofn_tx.sv
// Clocked e1ofN transmitter: buffers valid/ready words and sends each as one
// dual-rail four-phase token. Define E1OFN_TX_TIMEOUT_EN for the handshake timeout.
module e1ofn_tx
    import e1ofn_tx_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = 16
`ifdef E1OFN_TX_TIMEOUT_EN
    ,
    parameter int TO_W  = 12
`endif
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic [W-1:0]     tx_d0,
    output logic [W-1:0]     tx_d1,
    input  logic             tx_e,
    output logic [CNT_W-1:0] tx_count,
    output logic             idle,
    output logic             to_err
);

    localparam int AW = $clog2(DEPTH);

    logic e_s;

    sync2 u_sync_e (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (tx_e),
        .q     (e_s)
    );

    logic [W-1:0]  fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full     = (fifo_count == (AW+1)'(DEPTH));
    assign empty    = (fifo_count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    logic [W-1:0] head;
    logic [W-1:0] head_d1;
    logic [W-1:0] head_d0;

    assign head = fifo_mem[rd_ptr];

    // The package encoder is sized for the router's native token width.
    if (W == DEF_W) begin : g_pkg_enc
        assign {head_d1, head_d0} = dual_rail_enc(head);
    end else begin : g_local_enc
        assign head_d1 = head;
        assign head_d0 = ~head;
    end

    tx_state_t        state;
    tx_state_t        state_next;
    logic [W-1:0]     d0_next;
    logic [W-1:0]     d1_next;
    logic [CNT_W-1:0] count_next;

    // Rails, state and token count all register together so the rails never glitch.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            tx_d0    <= '0;
            tx_d1    <= '0;
            tx_count <= '0;
        end else begin
            state    <= state_next;
            tx_d0    <= d0_next;
            tx_d1    <= d1_next;
            tx_count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        d0_next    = tx_d0;
        d1_next    = tx_d1;
        count_next = tx_count;
        pop        = 1'b0;

        unique case (state)
            IDLE: begin
                d0_next = '0;
                d1_next = '0;
                if (!empty && e_s) begin
                    pop        = 1'b1;
                    d1_next    = head_d1;
                    d0_next    = head_d0;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (!e_s) begin
                    d0_next    = '0;
                    d1_next    = '0;
                    count_next = tx_count + 1'b1;
                    state_next = NEUTRAL;
                end
            end
            NEUTRAL: begin
                d0_next = '0;
                d1_next = '0;
                if (e_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                d0_next    = '0;
                d1_next    = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign idle = empty && (state == IDLE);

`ifdef E1OFN_TX_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_err_q;

    // Only flags a stuck handshake; the FSM keeps waiting for the receiver.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            to_cnt   <= '0;
            to_err_q <= 1'b0;
        end else begin
            if (state_next != state) begin
                to_cnt <= '0;
            end else if (state != IDLE && to_cnt != '1) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_cnt == '1) begin
                to_err_q <= 1'b1;
            end
        end
    end

    assign to_err = to_err_q;
`else
    assign to_err = 1'b0;
`endif

endmodule

// File: tb/tb_e1ofn_tx.sv
// Scoreboard bench for e1ofn_tx: directed vectors plus a randomly delayed
// four-phase receiver model that pops and checks each token it sees.
`timescale 1ns/1ps
module tb_e1ofn_tx;

    localparam int W     = 9;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic [W-1:0]     tx_d0;
    logic [W-1:0]     tx_d1;
    logic             tx_e;
    logic [CNT_W-1:0] tx_count;
    logic             idle;
    logic             to_err;

    logic tx_e_main = 1'b1;
    logic tx_e_rx   = 1'b1;
    bit   rx_auto   = 1'b0;
    bit   rx_waiting;
    int   rx_max_delay = 0;
    int   rx_tokens    = 0;
    int   rx_base      = 0;
    int   main_tokens  = 0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] exp_q [$];

    assign tx_e = rx_auto ? tx_e_rx : tx_e_main;

    e1ofn_tx #(
        .W     (W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
`ifdef E1OFN_TX_TIMEOUT_EN
        ,
        .TO_W  (4)
`endif
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx_d0    (tx_d0),
        .tx_d1    (tx_d1),
        .tx_e     (tx_e),
        .tx_count (tx_count),
        .idle     (idle),
        .to_err   (to_err)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [CNT_W-1:0] expected_count();
        return CNT_W'(rx_tokens - rx_base + main_tokens);
    endfunction

    // Caller sits on a negedge; the word is pushed to the scoreboard on acceptance.
    task automatic apply_stimulus(input logic [W-1:0] word, input int max_wait,
                                  output bit accepted);
        accepted = 1'b0;
        in_data  = word;
        in_valid = 1'b1;
        for (int i = 0; i < max_wait; i++) begin
            if (in_ready) begin
                @(posedge CLK);
                exp_q.push_back(word);
                accepted = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (accepted) @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && idle && rx_waiting) && n < 4000) begin
            @(negedge CLK);
            n++;
        end
        check_output(name, 32'(n < 4000), 32'd1);
    endtask

    always @(negedge CLK) begin
        if ((tx_d0 | tx_d1) != '0) begin
            check_output("rail_exclusive", 32'(tx_d0 & tx_d1), 32'd0);
        end
    end

    // Receiver model: raise enable, take a token, hold a while, acknowledge, rest.
    initial begin : receiver
        int           waited;
        int           dly;
        int           rel_cycles;
        bit           stable;
        logic [W-1:0] seen_d1;
        logic [W-1:0] seen_d0;
        logic [W-1:0] exp_w;
        logic [W-1:0] exp_d0;
        forever begin
            waited     = 0;
            rx_waiting = 1'b1;
            forever begin
                @(negedge CLK);
                if (rx_auto) begin
                    tx_e_rx = 1'b1;
                    if (&(tx_d0 ^ tx_d1)) break;
                    if (exp_q.size() != 0) waited++;
                    if (waited > 300) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL token_timeout: got no token, expected %0h", exp_q[0]);
                        void'(exp_q.pop_front());
                        waited = 0;
                    end
                end else begin
                    waited = 0;
                end
            end
            rx_waiting = 1'b0;
            seen_d1 = tx_d1;
            seen_d0 = tx_d0;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_token: got %0h, expected none", seen_d1);
            end else begin
                exp_w  = exp_q.pop_front();
                exp_d0 = ~exp_w;
                check_output("token_d1", 32'(seen_d1), 32'(exp_w));
                check_output("token_d0", 32'(seen_d0), 32'(exp_d0));
            end
            dly    = $urandom_range(rx_max_delay, 0);
            stable = 1'b1;
            repeat (dly) begin
                @(negedge CLK);
                if (tx_d1 !== seen_d1 || tx_d0 !== seen_d0) stable = 1'b0;
            end
            check_output("hold_stable", 32'(stable), 32'd1);
            tx_e_rx    = 1'b0;
            rel_cycles = 0;
            for (int i = 1; i <= 6 && rel_cycles == 0; i++) begin
                @(negedge CLK);
                if ((tx_d0 | tx_d1) == '0) rel_cycles = i;
            end
            check_output("release_latency", 32'(rel_cycles), 32'd3);
            rx_tokens++;
            dly = $urandom_range(rx_max_delay, 0);
            repeat (dly) @(negedge CLK);
        end
    end

    initial begin : watchdog
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        bit           ok;
        logic [W-1:0] bp_words [5];
        bp_words = '{9'h011, 9'h122, 9'h033, 9'h1C4, 9'h0E5};

        RESET    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check_output("rst_d0", 32'(tx_d0), 32'd0);
        check_output("rst_d1", 32'(tx_d1), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_idle", 32'(idle), 32'd1);
        check_output("rst_count", 32'(tx_count), 32'd0);
        check_output("rst_to_err", 32'(to_err), 32'd0);
        repeat (2) @(negedge CLK);

        apply_stimulus(9'h1A5, 4, ok);
        check_output("single_accept", 32'(ok), 32'd1);
        check_output("single_early", 32'(tx_d1), 32'd0);
        @(negedge CLK);
        check_output("single_d1", 32'(tx_d1), 32'h1A5);
        check_output("single_d0", 32'(tx_d0), 32'h05A);
        check_output("single_busy", 32'(idle), 32'd0);
        tx_e_main = 1'b0;
        repeat (2) @(negedge CLK);
        check_output("single_hold", 32'(tx_d1), 32'h1A5);
        @(negedge CLK);
        check_output("single_release", 32'({tx_d1, tx_d0}), 32'd0);
        main_tokens++;
        check_output("single_count", 32'(tx_count), 32'd1);
        tx_e_main = 1'b1;
        repeat (2) @(negedge CLK);
        check_output("single_neutral", 32'(idle), 32'd0);
        @(negedge CLK);
        check_output("single_idle", 32'(idle), 32'd1);
        exp_q.delete();

        tx_e_main = 1'b0;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(bp_words[i], 4, ok);
            check_output("bp_accept", 32'(ok), 32'd1);
        end
        check_output("bp_full", 32'(in_ready), 32'd0);
        check_output("bp_rails", 32'({tx_d1, tx_d0}), 32'd0);
        apply_stimulus(bp_words[4], 4, ok);
        check_output("bp_reject", 32'(ok), 32'd0);
        check_output("bp_rails_held", 32'({tx_d1, tx_d0}), 32'd0);
        check_output("bp_busy", 32'(idle), 32'd0);
        tx_e_main    = 1'b1;
        rx_max_delay = 0;
        rx_auto      = 1'b1;
        wait_drain("bp_drain");
        check_output("bp_count", 32'(tx_count), 32'(expected_count()));
        rx_auto = 1'b0;
        repeat (2) @(negedge CLK);

        apply_stimulus(9'h0F3, 4, ok);
        check_output("to_accept", 32'(ok), 32'd1);
        @(negedge CLK);
        check_output("to_d1", 32'(tx_d1), 32'h0F3);
        repeat (20) @(negedge CLK);
        check_output("to_hold_d1", 32'(tx_d1), 32'h0F3);
        check_output("to_hold_d0", 32'(tx_d0), 32'h10C);
`ifdef E1OFN_TX_TIMEOUT_EN
        check_output("to_err_set", 32'(to_err), 32'd1);
`else
        check_output("to_err_off", 32'(to_err), 32'd0);
`endif
        tx_e_main = 1'b0;
        repeat (3) @(negedge CLK);
        check_output("to_release", 32'({tx_d1, tx_d0}), 32'd0);
        main_tokens++;
        tx_e_main = 1'b1;
        repeat (3) @(negedge CLK);
        check_output("to_idle", 32'(idle), 32'd1);
`ifdef E1OFN_TX_TIMEOUT_EN
        check_output("to_err_sticky", 32'(to_err), 32'd1);
`else
        check_output("to_err_off_after", 32'(to_err), 32'd0);
`endif
        check_output("to_count", 32'(tx_count), 32'(expected_count()));

        apply_stimulus(9'h15A, 4, ok);
        apply_stimulus(9'h0C3, 4, ok);
        check_output("rmd_d1", 32'(tx_d1), 32'h15A);
        check_output("rmd_queued", 32'(idle), 32'd0);
        RESET = 1'b1;
        #1;
        check_output("rmd_rails", 32'({tx_d1, tx_d0}), 32'd0);
        check_output("rmd_idle", 32'(idle), 32'd1);
        check_output("rmd_in_ready", 32'(in_ready), 32'd1);
        check_output("rmd_count", 32'(tx_count), 32'd0);
        check_output("rmd_to_err", 32'(to_err), 32'd0);
        @(negedge CLK);
        RESET       = 1'b0;
        rx_base     = rx_tokens;
        main_tokens = 0;
        exp_q.delete();
        repeat (6) @(negedge CLK);
        check_output("rmd_lost_word", 32'({tx_d1, tx_d0}), 32'd0);
        check_output("rmd_still_idle", 32'(idle), 32'd1);

        rx_max_delay = 20;
        rx_auto      = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            apply_stimulus(W'($urandom), 300, ok);
            if (!ok) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL rand_push: got stalled push %0d, expected acceptance", i);
            end
            repeat ($urandom_range(2, 0)) @(negedge CLK);
        end
        wait_drain("rand_drain");
        check_output("rand_tokens", 32'(rx_tokens - rx_base), 32'd1000);
        check_output("rand_count", 32'(tx_count), 32'(expected_count()));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
